// File: rtl/reorder_tag_issuer_if.sv
// Request, issue and response channels between an initiator and the reorder tag issuer.
// The issuer connects through the slave modport; the initiator/bench through master.
interface reorder_tag_issuer_if #(
  parameter int TAG_BITS  = 2,
  parameter int BEAT_BITS = 3
);
  // upstream request
  logic                 req_ready;
  logic                 req_valid;
  logic [BEAT_BITS-1:0] req_addr_beat;
  logic                 req_subblock;
  logic [BEAT_BITS-1:0] req_len;

  // issued (tagged) request
  logic                 out_valid;
  logic                 out_ready;
  logic [TAG_BITS-1:0]  out_tag;
  logic [BEAT_BITS-1:0] out_addr_beat;
  logic                 out_subblock;
  logic [BEAT_BITS-1:0] out_len;

  // tagged response beats and their decode
  logic                 rsp_valid;
  logic [TAG_BITS-1:0]  rsp_tag;
  logic                 rsp_last;
  logic                 rsp_hit;
  logic [BEAT_BITS-1:0] rsp_addr_beat;
  logic                 rsp_subblock;

  modport master (
    input  req_ready,
    output req_valid, req_addr_beat, req_subblock, req_len,
    input  out_valid, out_tag, out_addr_beat, out_subblock, out_len,
    output out_ready,
    output rsp_valid, rsp_tag, rsp_last,
    input  rsp_hit, rsp_addr_beat, rsp_subblock
  );

  modport slave (
    output req_ready,
    input  req_valid, req_addr_beat, req_subblock, req_len,
    output out_valid, out_tag, out_addr_beat, out_subblock, out_len,
    input  out_ready,
    input  rsp_valid, rsp_tag, rsp_last,
    output rsp_hit, rsp_addr_beat, rsp_subblock
  );
endinterface

// File: rtl/reorder_tag_issuer.sv
// Tag issuer: allocates tags from a free pool, issues requests through a one-entry
// output register, decodes out-of-order response beats and retires tags on last beat.
module reorder_tag_issuer #(
  parameter int TAG_BITS  = 2,
  parameter int BEAT_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  reorder_tag_issuer_if.slave bus,
  output logic [TAG_BITS:0]   inflight,
  output logic                err
);
  localparam int NTAGS = 2**TAG_BITS;

  // per-tag state
  logic                 free_reg     [NTAGS];
  logic [BEAT_BITS-1:0] cnt_reg      [NTAGS];
  logic [BEAT_BITS-1:0] tbl_addr_reg [NTAGS];
  logic                 tbl_sb_reg   [NTAGS];
  logic [BEAT_BITS-1:0] tbl_len_reg  [NTAGS];
  logic [NTAGS-1:0]     free_vec;

  // output register and status
  logic                 out_valid_reg;
  logic [TAG_BITS-1:0]  out_tag_reg;
  logic [BEAT_BITS-1:0] out_addr_beat_reg;
  logic                 out_subblock_reg;
  logic [BEAT_BITS-1:0] out_len_reg;
  logic [TAG_BITS:0]    inflight_reg;
  logic                 err_reg;

  // combinational control
  logic [TAG_BITS-1:0]  alloc_tag;
  logic                 has_free;
  logic                 can_accept;
  logic                 fire;
  logic                 rsp_busy;
  logic                 rsp_hit_c;
  logic                 rsp_at_len;
  logic                 retire;
  logic [BEAT_BITS-1:0] rsp_cnt;

  // lowest-index free tag wins
  always_comb begin
    alloc_tag = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_tag = TAG_BITS'(i);
    end
  end

  assign has_free   = |free_vec;
  assign can_accept = has_free & (~out_valid_reg | bus.out_ready);
  assign fire       = bus.req_valid & can_accept;

  assign rsp_busy   = ~free_vec[bus.rsp_tag];
  assign rsp_hit_c  = bus.rsp_valid & rsp_busy;
  assign rsp_cnt    = cnt_reg[bus.rsp_tag];
  assign rsp_at_len = (rsp_cnt == tbl_len_reg[bus.rsp_tag]);
  assign retire     = rsp_hit_c & bus.rsp_last;

  // A tag that fires is free and a tag that hits is busy, so the two
  // branches below never target the same entry in one cycle.
  for (genvar gi = 0; gi < NTAGS; gi++) begin : g_tag
    logic alloc_here;
    logic rsp_here;

    assign alloc_here   = fire & (alloc_tag == TAG_BITS'(gi));
    assign rsp_here     = rsp_hit_c & (bus.rsp_tag == TAG_BITS'(gi));
    assign free_vec[gi] = free_reg[gi];

    always_ff @(posedge clk) begin
      if (reset) begin
        free_reg[gi] <= 1'b1;
        cnt_reg[gi]  <= '0;
      end else if (alloc_here) begin
        free_reg[gi] <= 1'b0;
        cnt_reg[gi]  <= '0;
      end else if (rsp_here) begin
        if (bus.rsp_last) begin
          free_reg[gi] <= 1'b1;
          cnt_reg[gi]  <= '0;
        end else begin
          cnt_reg[gi]  <= cnt_reg[gi] + BEAT_BITS'(1);
        end
      end
    end

    // metadata is only meaningful while the tag is busy, so it carries no reset
    always_ff @(posedge clk) begin
      if (alloc_here) begin
        tbl_addr_reg[gi] <= bus.req_addr_beat;
        tbl_sb_reg[gi]   <= bus.req_subblock;
        tbl_len_reg[gi]  <= bus.req_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg     <= 1'b0;
      out_tag_reg       <= '0;
      out_addr_beat_reg <= '0;
      out_subblock_reg  <= 1'b0;
      out_len_reg       <= '0;
    end else if (fire) begin
      out_valid_reg     <= 1'b1;
      out_tag_reg       <= alloc_tag;
      out_addr_beat_reg <= bus.req_addr_beat;
      out_subblock_reg  <= bus.req_subblock;
      out_len_reg       <= bus.req_len;
    end else if (bus.out_ready) begin
      out_valid_reg     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg <= '0;
    end else begin
      case ({fire, retire})
        2'b10:   inflight_reg <= inflight_reg + (TAG_BITS + 1)'(1);
        2'b01:   inflight_reg <= inflight_reg - (TAG_BITS + 1)'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // sticky: beats on idle tags, or last flag disagreeing with the recorded length
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (bus.rsp_valid & ~rsp_busy) begin
      err_reg <= 1'b1;
    end else if (rsp_hit_c & (bus.rsp_last != rsp_at_len)) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.req_ready     = can_accept;
  assign bus.out_valid     = out_valid_reg;
  assign bus.out_tag       = out_tag_reg;
  assign bus.out_addr_beat = out_addr_beat_reg;
  assign bus.out_subblock  = out_subblock_reg;
  assign bus.out_len       = out_len_reg;
  assign bus.rsp_hit       = rsp_hit_c;
  assign bus.rsp_addr_beat = tbl_addr_reg[bus.rsp_tag] + rsp_cnt;
  assign bus.rsp_subblock  = tbl_sb_reg[bus.rsp_tag];
  assign inflight          = inflight_reg;
  assign err               = err_reg;
endmodule

// File: tb/tb_reorder_tag_issuer.sv
// Directed bench for reorder_tag_issuer: allocation order, stalls, wrap decode,
// retire/allocate interaction and error flagging.
module tb_reorder_tag_issuer;
  localparam int TAG_BITS  = 2;
  localparam int BEAT_BITS = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [TAG_BITS:0] inflight;
  logic              err;
  int                total = 0;
  int                bad   = 0;

  reorder_tag_issuer_if #(.TAG_BITS(TAG_BITS), .BEAT_BITS(BEAT_BITS)) bus ();

  reorder_tag_issuer #(.TAG_BITS(TAG_BITS), .BEAT_BITS(BEAT_BITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .inflight (inflight),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [2:0] ab, input logic sb, input logic [2:0] len);
    bus.req_valid     = v;
    bus.req_addr_beat = ab;
    bus.req_subblock  = sb;
    bus.req_len       = len;
  endtask

  task automatic set_rsp(input logic v, input logic [1:0] tag, input logic last);
    bus.rsp_valid = v;
    bus.rsp_tag   = tag;
    bus.rsp_last  = last;
  endtask

  initial begin
    logic [3:0] sb_a;
    logic [3:0] sb_d;
    logic [2:0] ab_d [4];
    logic [2:0] wrap_exp [4];
    sb_a = 4'b1011;
    sb_d = 4'b1100;
    ab_d = '{3'd5, 3'd7, 3'd3, 3'd3};
    wrap_exp = '{3'd6, 3'd7, 3'd0, 3'd1};

    // reset state
    reset = 1'b1;
    set_req(0, 0, 0, 0);
    set_rsp(0, 0, 0);
    bus.out_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_tag", 32'(bus.out_tag), 0);
    chk("rst_out_addr_beat", 32'(bus.out_addr_beat), 0);
    chk("rst_out_len", 32'(bus.out_len), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);

    // four back-to-back requests get tags 0..3
    for (int i = 0; i < 4; i++) begin
      set_req(1, 3'(i), sb_a[i], 0);
      #1 chk("a_req_ready", 32'(bus.req_ready), 1);
      step();
      chk("a_out_valid", 32'(bus.out_valid), 1);
      chk("a_out_tag", 32'(bus.out_tag), 32'(i));
      chk("a_out_addr_beat", 32'(bus.out_addr_beat), 32'(i));
    end
    #1 chk("a_full_req_ready", 32'(bus.req_ready), 0);
    chk("a_inflight", 32'(inflight), 4);
    set_req(0, 0, 0, 0);
    step();
    chk("a_out_drop", 32'(bus.out_valid), 0);

    // retire tag 2 then tag 0; next allocations reuse 0 then 2
    set_rsp(1, 2, 1);
    #1 chk("c_hit2", 32'(bus.rsp_hit), 1);
    chk("c_sb2", 32'(bus.rsp_subblock), 32'(sb_a[2]));
    chk("c_ab2", 32'(bus.rsp_addr_beat), 2);
    step();
    set_rsp(1, 0, 1);
    #1 chk("c_hit0", 32'(bus.rsp_hit), 1);
    chk("c_sb0", 32'(bus.rsp_subblock), 32'(sb_a[0]));
    chk("c_ab0", 32'(bus.rsp_addr_beat), 0);
    step();
    set_rsp(0, 0, 0);
    chk("c_inflight2", 32'(inflight), 2);
    chk("c_err", 32'(err), 0);
    set_req(1, 5, 0, 0);
    #1 chk("c_req_ready", 32'(bus.req_ready), 1);
    step();
    chk("c_tag_first", 32'(bus.out_tag), 0);
    chk("c_ab_first", 32'(bus.out_addr_beat), 5);
    set_req(1, 3, 1, 0);
    step();
    chk("c_tag_second", 32'(bus.out_tag), 2);
    set_req(0, 0, 0, 0);
    step();
    chk("c_out_drop", 32'(bus.out_valid), 0);
    chk("c_inflight4", 32'(inflight), 4);

    // pool full: retire tag 1 and request in the same cycle
    set_rsp(1, 1, 1);
    set_req(1, 7, 0, 0);
    #1 chk("d_req_ready_blocked", 32'(bus.req_ready), 0);
    chk("d_hit1", 32'(bus.rsp_hit), 1);
    chk("d_sb1", 32'(bus.rsp_subblock), 1);
    step();
    set_rsp(0, 0, 0);
    chk("d_no_fire", 32'(bus.out_valid), 0);
    chk("d_inflight3", 32'(inflight), 3);
    #1 chk("d_req_ready_now", 32'(bus.req_ready), 1);
    step();
    chk("d_out_tag1", 32'(bus.out_tag), 1);
    chk("d_out_ab", 32'(bus.out_addr_beat), 7);
    chk("d_inflight4", 32'(inflight), 4);
    set_req(0, 0, 0, 0);
    step();

    // drain all four tags, checking stored metadata
    for (int t = 0; t < 4; t++) begin
      set_rsp(1, 2'(t), 1);
      #1 chk("d_drain_hit", 32'(bus.rsp_hit), 1);
      chk("d_drain_sb", 32'(bus.rsp_subblock), 32'(sb_d[t]));
      chk("d_drain_ab", 32'(bus.rsp_addr_beat), 32'(ab_d[t]));
      step();
    end
    set_rsp(0, 0, 0);
    chk("d_drain_inflight", 32'(inflight), 0);
    chk("d_drain_err", 32'(err), 0);

    // four-beat burst from addr_beat 6 wraps the decoded beat index
    set_req(1, 6, 0, 3);
    step();
    set_req(0, 0, 0, 0);
    chk("b_out_tag", 32'(bus.out_tag), 0);
    for (int b = 0; b < 4; b++) begin
      set_rsp(1, 0, (b == 3));
      #1 chk("b_hit", 32'(bus.rsp_hit), 1);
      chk("b_ab", 32'(bus.rsp_addr_beat), 32'(wrap_exp[b]));
      step();
    end
    set_rsp(0, 0, 0);
    chk("b_err", 32'(err), 0);
    chk("b_inflight", 32'(inflight), 0);

    // downstream stall holds the output register
    bus.out_ready = 1'b0;
    set_req(1, 2, 1, 0);
    step();
    chk("e_tag0_free", 32'(bus.out_tag), 0);
    set_req(1, 4, 0, 1);
    for (int k = 0; k < 3; k++) begin
      #1 chk("e_req_ready_stall", 32'(bus.req_ready), 0);
      step();
      chk("e_hold_valid", 32'(bus.out_valid), 1);
      chk("e_hold_tag", 32'(bus.out_tag), 0);
      chk("e_hold_ab", 32'(bus.out_addr_beat), 2);
      chk("e_hold_sb", 32'(bus.out_subblock), 1);
    end
    bus.out_ready = 1'b1;
    #1 chk("e_req_ready_go", 32'(bus.req_ready), 1);
    step();
    chk("e_reload_valid", 32'(bus.out_valid), 1);
    chk("e_reload_tag", 32'(bus.out_tag), 1);
    chk("e_reload_ab", 32'(bus.out_addr_beat), 4);
    chk("e_reload_len", 32'(bus.out_len), 1);
    chk("e_inflight", 32'(inflight), 2);
    set_req(0, 0, 0, 0);
    step();
    chk("e_out_drop", 32'(bus.out_valid), 0);
    set_rsp(1, 0, 1);
    #1 chk("e_hit0", 32'(bus.rsp_hit), 1);
    step();
    set_rsp(1, 1, 0);
    #1 chk("e_ab_beat0", 32'(bus.rsp_addr_beat), 4);
    step();
    set_rsp(1, 1, 1);
    #1 chk("e_ab_beat1", 32'(bus.rsp_addr_beat), 5);
    step();
    set_rsp(0, 0, 0);
    chk("e_err", 32'(err), 0);
    chk("e_inflight0", 32'(inflight), 0);

    // response on a free tag
    set_rsp(1, 3, 0);
    #1 chk("f_free_hit", 32'(bus.rsp_hit), 0);
    step();
    set_rsp(0, 0, 0);
    chk("f_free_err", 32'(err), 1);
    chk("f_free_inflight", 32'(inflight), 0);

    // early last beat: err set, tag still freed
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("f_err_cleared", 32'(err), 0);
    set_req(1, 0, 0, 1);
    step();
    set_req(0, 0, 0, 0);
    chk("f_len_tag", 32'(bus.out_tag), 0);
    set_rsp(1, 0, 1);
    #1 chk("f_len_hit", 32'(bus.rsp_hit), 1);
    step();
    set_rsp(0, 0, 0);
    chk("f_len_err", 32'(err), 1);
    chk("f_len_inflight", 32'(inflight), 0);
    set_rsp(1, 0, 0);
    #1 chk("f_len_freed", 32'(bus.rsp_hit), 0);
    set_rsp(0, 0, 0);

    // reset mid-operation drops outstanding tags
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(1, 1, 0, 0);
    step();
    set_req(0, 0, 0, 0);
    chk("g_inflight1", 32'(inflight), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("g_inflight_rst", 32'(inflight), 0);
    chk("g_out_valid_rst", 32'(bus.out_valid), 0);
    set_rsp(1, 0, 1);
    #1 chk("g_stale_hit", 32'(bus.rsp_hit), 0);
    step();
    set_rsp(0, 0, 0);
    chk("g_stale_err", 32'(err), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reorder_tag_issuer.md
Name: reorder_tag_issuer

Overview:
- Initiator-side companion to the tag-indexed reorder queue.
- Accepts upstream requests, allocates a free tag from a pool of NTAGS, and issues the tagged request downstream through a one-entry output register.
- Records per-tag beat metadata. Decodes out-of-order tagged response beats back into their original addr_beat/subblock.
- Retires each tag on its last beat.

Parameters:
TAG_BITS, 2, tag width; NTAGS = 2**TAG_BITS
BEAT_BITS, 3, addr_beat / length width

Ports:
clk  in  1  clock
reset  in  1  reset
req_ready  out  1  upstream request accepted when high with req_valid
req_valid  in  1  upstream request present
req_addr_beat  in  BEAT_BITS  starting beat of request
req_subblock  in  1  subblock flag of request
req_len  in  BEAT_BITS  number of beats minus one
out_valid  out  1  issued request valid
out_ready  in  1  downstream accepts issued request
out_tag  out  TAG_BITS  allocated tag
out_addr_beat  out  BEAT_BITS  copy of req_addr_beat
out_subblock  out  1  copy of req_subblock
out_len  out  BEAT_BITS  copy of req_len
rsp_valid  in  1  response beat present (always consumed)
rsp_tag  in  TAG_BITS  tag of response beat
rsp_last  in  1  final beat of this tag
rsp_hit  out  1  rsp_valid and rsp_tag currently in flight
rsp_addr_beat  out  BEAT_BITS  decoded beat index for this response
rsp_subblock  out  1  stored subblock for rsp_tag
inflight  out  TAG_BITS+1  number of busy tags
err  out  1  sticky protocol error

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values:
  - free vector all ones; beat counters 0.
  - out_valid 0, out_tag/out_addr_beat/out_subblock/out_len 0.
  - inflight 0, err 0.
  - Metadata table is not reset.
- Allocation:
  - alloc_tag = lowest-index set bit of the registered free vector.
  - has_free = OR of the free vector.
  - req_ready = has_free & (!out_valid | out_ready). This is combinational and does not depend on req_valid.
- Request fire (req_valid & req_ready):
  - clear free[alloc_tag].
  - write {addr_beat, subblock, len} to table[alloc_tag]; clear cnt[alloc_tag].
  - load output register with alloc_tag and request fields; out_valid = 1 next cycle.
- Output register:
  - on out_valid & out_ready with no new fire, out_valid drops to 0.
  - with a same-cycle fire, the register reloads (zero-bubble throughput).
  - out_* fields are stable while out_valid & !out_ready.
- Response decode (combinational, same cycle):
  - rsp_hit = rsp_valid & !free[rsp_tag].
  - rsp_addr_beat = table[rsp_tag].addr_beat + cnt[rsp_tag], modulo 2**BEAT_BITS (wraps).
  - rsp_subblock = table[rsp_tag].subblock.
  - these outputs are don't-care when rsp_hit = 0.
- Response update (rsp_hit):
  - if rsp_last: set free[rsp_tag], clear cnt[rsp_tag].
  - otherwise: cnt[rsp_tag] += 1.
  - set err if rsp_last != (cnt[rsp_tag] == table[rsp_tag].len).
  - the tag is freed on rsp_last regardless of mismatch.
- rsp_valid with the tag already free: no state change, err set.
- Simultaneous retire and allocate: allocation uses the registered free vector, so a tag freed this cycle is allocatable next cycle at the earliest. The same tag is never both freed and allocated in one cycle.
- Response for a tag whose request still sits in the output register is legal and is processed normally.
- inflight = NTAGS - popcount(free), registered, updated with fire and retire in the same cycle (+1, -1, or net 0).
- err is sticky until reset.
- Reset mid-operation clears all tags; responses arriving afterwards are flagged as err.

Test Plan:
- 4 requests back-to-back, out_ready=1 -> out_tag 0,1,2,3 on consecutive cycles; req_ready=0 after 4th fire; inflight=4.
- Request addr_beat=6, len=3, tag 0; rsp_valid on tag 0 for 4 beats, last on 4th -> rsp_addr_beat 6,7,0,1 (wrap); tag 0 free next cycle; err=0.
- Tags 0..3 in flight; responses retire in order 2,0 -> next two requests receive tags 0 then 2; rsp_subblock matches each stored value.
- Pool full, retire tag 1 and assert req_valid in the same cycle -> no fire that cycle; fire next cycle with out_tag=1.
- out_ready=0 for 3 cycles with out_valid=1 -> out_* held constant, req_ready=0; out_ready=1 with req_valid=1 -> issue and reload in the same cycle.
- rsp_valid on free tag 3 -> rsp_hit=0, err=1 next cycle. Separately, len=1 with rsp_last on the first beat -> err=1 and the tag is freed.
